// File: rtl/rv_soc_apb_decoder.sv
// ---------------------------------------------------------------------------
// rv_soc_apb_decoder
//
// APB decoder/multiplexer connecting one APB master to SLAVES APB slaves.
// Each slave i claims an address when ((PADDR ^ slv_addr[i]) & slv_mask[i])
// is zero. If several slaves claim an address, the lowest index wins.
// Unmapped addresses get an immediate error response. A per-transfer
// watchdog ends a hung access with PSLVERR and raises a sticky flag.
//
// Ports
//   PCLK, PRESETn            clock, asynchronous active-low reset
//   PSEL/PENABLE/PADDR       master request
//   PRDATA/PREADY/PSLVERR    response to the master
//   slv_addr/slv_mask        base address and compare mask per slave
//   SLV_PSEL                 select per slave
//   SLV_PRDATA/PREADY/PSLVERR response from each slave
//   timeout_o                one-cycle pulse when the watchdog ends a transfer
//   tout_sticky_o/tout_clr_i sticky timeout flag and its clear
//
// Optional build macro RV_SOC_APB_DECODER_ERRLOG_EN adds a first-error log:
//   err_valid_o, err_addr_o, err_type_o (01 unmapped, 10 timeout,
//   11 slave PSLVERR). tout_clr_i also clears the log.
//
// Handshake: a transfer is a setup cycle (PSEL=1, PENABLE=0) followed by
// access cycles (PSEL=1, PENABLE=1). The transfer completes in the first
// access cycle where PREADY=1. PADDR is sampled only in the setup cycle.
// ---------------------------------------------------------------------------
module rv_soc_apb_decoder #(
    parameter int                    PADDR_SIZE = 16,
    parameter int                    PDATA_SIZE = 8,
    parameter int                    SLAVES     = 8,
    parameter int                    TIMEOUT    = 255,
    parameter logic [PDATA_SIZE-1:0] ERR_PRDATA = '0
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic [PADDR_SIZE-1:0] PADDR,
    output logic [PDATA_SIZE-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    input  logic [PADDR_SIZE-1:0] slv_addr    [SLAVES],
    input  logic [PADDR_SIZE-1:0] slv_mask    [SLAVES],
    output logic [SLAVES-1:0]     SLV_PSEL,
    input  logic [PDATA_SIZE-1:0] SLV_PRDATA  [SLAVES],
    input  logic [SLAVES-1:0]     SLV_PREADY,
    input  logic [SLAVES-1:0]     SLV_PSLVERR,
    output logic                  timeout_o,
    output logic                  tout_sticky_o,
    input  logic                  tout_clr_i
`ifdef RV_SOC_APB_DECODER_ERRLOG_EN
    ,
    output logic                  err_valid_o,
    output logic [PADDR_SIZE-1:0] err_addr_o,
    output logic [1:0]            err_type_o
`endif
);

    localparam int IDX_W = (SLAVES > 1) ? $clog2(SLAVES) : 1;
    // A zero TIMEOUT would give a zero-width counter; keep one bit unused.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ABORT  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               hit_q, hit_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               tout_sticky_q, tout_sticky_d;

    logic [IDX_W-1:0]   win_idx;
    logic               any_match;
    logic               wd_expired;
    logic               err_cmpl;
    logic [1:0]         err_kind;

    // Priority decode: scan from the top down so the lowest match is kept.
    always_comb begin
        win_idx   = '0;
        any_match = 1'b0;
        for (int i = SLAVES - 1; i >= 0; i--) begin
            if (((PADDR ^ slv_addr[i]) & slv_mask[i]) == '0) begin
                any_match = 1'b1;
                win_idx   = IDX_W'(i);
            end
        end
    end

    assign wd_expired = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT));

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        hit_d     = hit_q;
        cnt_d     = cnt_q;
        SLV_PSEL  = '0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        PRDATA    = '0;
        timeout_o = 1'b0;
        err_cmpl  = 1'b0;
        err_kind  = 2'b00;
        case (state_q)
            ST_IDLE: begin
                if (PSEL && any_match) SLV_PSEL[win_idx] = 1'b1;
                if (PSEL && !PENABLE) begin
                    idx_d   = win_idx;
                    hit_d   = any_match;
                    cnt_d   = '0;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                SLV_PSEL[idx_q] = PSEL & hit_q;
                if (!PSEL) begin
                    // Master dropped the transfer: leave without a response.
                    state_d = ST_IDLE;
                end else if (!hit_q) begin
                    PREADY   = 1'b1;
                    PSLVERR  = 1'b1;
                    PRDATA   = ERR_PRDATA;
                    err_cmpl = 1'b1;
                    err_kind = 2'b01;
                    state_d  = ST_IDLE;
                end else if (SLV_PREADY[idx_q]) begin
                    // A slave completing on the watchdog cycle still wins.
                    PREADY   = 1'b1;
                    PSLVERR  = SLV_PSLVERR[idx_q];
                    PRDATA   = SLV_PRDATA[idx_q];
                    err_cmpl = SLV_PSLVERR[idx_q];
                    err_kind = 2'b11;
                    state_d  = ST_IDLE;
                end else if (wd_expired) begin
                    PREADY    = 1'b1;
                    PSLVERR   = 1'b1;
                    PRDATA    = ERR_PRDATA;
                    timeout_o = 1'b1;
                    err_cmpl  = 1'b1;
                    err_kind  = 2'b10;
                    state_d   = ST_ABORT;
                end else begin
                    // Wait state: slave data and error pass through.
                    PSLVERR = SLV_PSLVERR[idx_q];
                    PRDATA  = SLV_PRDATA[idx_q];
                    if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_ABORT: begin
                // One dead cycle so the hung slave sees its select drop.
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Set wins over clear.
        if (timeout_o)       tout_sticky_d = 1'b1;
        else if (tout_clr_i) tout_sticky_d = 1'b0;
        else                 tout_sticky_d = tout_sticky_q;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            hit_q         <= 1'b0;
            cnt_q         <= '0;
            tout_sticky_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            hit_q         <= hit_d;
            cnt_q         <= cnt_d;
            tout_sticky_q <= tout_sticky_d;
        end
    end

    assign tout_sticky_o = tout_sticky_q;

`ifdef RV_SOC_APB_DECODER_ERRLOG_EN
    logic [PADDR_SIZE-1:0] addr_q, addr_d;
    logic                  err_valid_q, err_valid_d;
    logic [PADDR_SIZE-1:0] err_addr_q, err_addr_d;
    logic [1:0]            err_type_q, err_type_d;

    always_comb begin
        addr_d      = addr_q;
        err_valid_d = err_valid_q;
        err_addr_d  = err_addr_q;
        err_type_d  = err_type_q;
        if (state_q == ST_IDLE && PSEL && !PENABLE) addr_d = PADDR;
        // A new error in the clearing cycle is captured rather than lost.
        if (err_cmpl && (!err_valid_q || tout_clr_i)) begin
            err_valid_d = 1'b1;
            err_addr_d  = addr_q;
            err_type_d  = err_kind;
        end else if (tout_clr_i) begin
            err_valid_d = 1'b0;
            err_addr_d  = '0;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            addr_q      <= '0;
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
            err_type_q  <= 2'b00;
        end else begin
            addr_q      <= addr_d;
            err_valid_q <= err_valid_d;
            err_addr_q  <= err_addr_d;
            err_type_q  <= err_type_d;
        end
    end

    assign err_valid_o = err_valid_q;
    assign err_addr_o  = err_addr_q;
    assign err_type_o  = err_type_q;
`else
    // err_kind only feeds the error log.
    logic unused_err;
    assign unused_err = err_cmpl ^ (^err_kind);
`endif

endmodule

// File: tb/tb_rv_soc_apb_decoder.sv
// ---------------------------------------------------------------------------
// tb_rv_soc_apb_decoder
//
// Bench for rv_soc_apb_decoder with 4 slaves, TIMEOUT=4 and ERR_PRDATA=0xEE.
// Each slave is a simple model that raises PREADY after wait_cfg[i] access
// cycles. The expected {PSLVERR, PRDATA} of a read is queued when its setup
// phase is driven and popped when the decoder raises PREADY.
// ---------------------------------------------------------------------------
module tb_rv_soc_apb_decoder;

    localparam int             AW    = 16;
    localparam int             DW    = 8;
    localparam int             NS    = 4;
    localparam int             TO    = 4;
    localparam logic [DW-1:0]  ERR_D = 8'hEE;
    localparam int             HANG  = 1000;

    logic           PCLK    = 1'b0;
    logic           PRESETn = 1'b0;
    logic           PSEL    = 1'b0;
    logic           PENABLE = 1'b0;
    logic [AW-1:0]  PADDR   = '0;
    logic [DW-1:0]  PRDATA;
    logic           PREADY;
    logic           PSLVERR;
    logic [AW-1:0]  slv_addr   [NS];
    logic [AW-1:0]  slv_mask   [NS];
    logic [NS-1:0]  SLV_PSEL;
    logic [DW-1:0]  SLV_PRDATA [NS];
    logic [NS-1:0]  SLV_PREADY;
    logic [NS-1:0]  SLV_PSLVERR = '0;
    logic           timeout_o;
    logic           tout_sticky_o;
    logic           tout_clr_i  = 1'b0;
`ifdef RV_SOC_APB_DECODER_ERRLOG_EN
    logic           err_valid_o;
    logic [AW-1:0]  err_addr_o;
    logic [1:0]     err_type_o;
`endif

    rv_soc_apb_decoder #(
        .PADDR_SIZE (AW),
        .PDATA_SIZE (DW),
        .SLAVES     (NS),
        .TIMEOUT    (TO),
        .ERR_PRDATA (ERR_D)
    ) dut (
        .PCLK          (PCLK),
        .PRESETn       (PRESETn),
        .PSEL          (PSEL),
        .PENABLE       (PENABLE),
        .PADDR         (PADDR),
        .PRDATA        (PRDATA),
        .PREADY        (PREADY),
        .PSLVERR       (PSLVERR),
        .slv_addr      (slv_addr),
        .slv_mask      (slv_mask),
        .SLV_PSEL      (SLV_PSEL),
        .SLV_PRDATA    (SLV_PRDATA),
        .SLV_PREADY    (SLV_PREADY),
        .SLV_PSLVERR   (SLV_PSLVERR),
        .timeout_o     (timeout_o),
        .tout_sticky_o (tout_sticky_o),
        .tout_clr_i    (tout_clr_i)
`ifdef RV_SOC_APB_DECODER_ERRLOG_EN
        ,
        .err_valid_o   (err_valid_o),
        .err_addr_o    (err_addr_o),
        .err_type_o    (err_type_o)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 PCLK = ~PCLK;

    initial begin
        #200000;
        $display("FAIL sim_watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // ---------------- slave model ----------------
    int wait_cfg [NS];
    int wcnt = 0;

    always @(posedge PCLK) begin
        if ((|SLV_PSEL) && PENABLE) wcnt <= wcnt + 1;
        else                        wcnt <= 0;
    end

    always_comb begin
        for (int i = 0; i < NS; i++) SLV_PREADY[i] = (wcnt >= wait_cfg[i]);
    end

    int tout_pulses = 0;
    always @(negedge PCLK) if (timeout_o === 1'b1) tout_pulses++;

    // ---------------- scoreboard ----------------
    logic [DW:0] exp_q [$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic apb_read(input logic [AW-1:0] addr, input logic [NS-1:0] exp_sel,
                            input logic exp_err, input logic [DW-1:0] exp_data,
                            input int exp_cycles);
        logic [DW:0] exp;
        int          cyc;
        bit          done;
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PADDR = addr;
        exp_q.push_back({exp_err, exp_data});
        @(negedge PCLK);
        check("setup_sel", 32'(SLV_PSEL), 32'(exp_sel));
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        // Decoder must ignore address changes during the access phase.
        PADDR   = 16'hFFFF;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 20) begin
            @(negedge PCLK);
            cyc++;
            if (cyc == 1) check("access_sel", 32'(SLV_PSEL), 32'(exp_sel));
            if (PREADY === 1'b1) begin
                exp = exp_q.pop_front();
                check("resp", 32'({PSLVERR, PRDATA}), 32'(exp));
                check("acc_cycles", 32'(cyc), 32'(exp_cycles));
                done = 1'b1;
            end
        end
        if (!done) begin
            check("ready_wait", 32'(0), 32'(1));
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        slv_addr[0] = 16'h0000; slv_mask[0] = 16'hFFF0;
        slv_addr[1] = 16'h0010; slv_mask[1] = 16'hFFF0;
        slv_addr[2] = 16'h1000; slv_mask[2] = 16'hFFF0;
        slv_addr[3] = 16'h2000; slv_mask[3] = 16'hFFF0;
        SLV_PRDATA[0] = 8'h3C; SLV_PRDATA[1] = 8'hA5;
        SLV_PRDATA[2] = 8'h5A; SLV_PRDATA[3] = 8'hC3;
        for (int i = 0; i < NS; i++) wait_cfg[i] = 0;

        // Reset values
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        check("rst_pready",  32'(PREADY), 32'(0));
        check("rst_pslverr", 32'(PSLVERR), 32'(0));
        check("rst_prdata",  32'(PRDATA), 32'(0));
        check("rst_timeout", 32'(timeout_o), 32'(0));
        check("rst_sticky",  32'(tout_sticky_o), 32'(0));
        check("rst_slv_psel", 32'(SLV_PSEL), 32'(0));
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        idle(1);

        // Basic mapped read, zero wait states
        apb_read(16'h0014, 4'b0010, 1'b0, 8'hA5, 1);

        // Overlap: slave2 matches everything, slave0 must win
        slv_addr[2] = 16'h0000; slv_mask[2] = 16'h0000;
        apb_read(16'h0004, 4'b0001, 1'b0, 8'h3C, 1);
        slv_addr[2] = 16'h3000; slv_mask[2] = 16'hFFF0;

        // Unmapped: immediate error response
        apb_read(16'h8000, 4'b0000, 1'b1, ERR_D, 1);
`ifdef RV_SOC_APB_DECODER_ERRLOG_EN
        check("log_valid_unm", 32'(err_valid_o), 32'(1));
        check("log_addr_unm",  32'(err_addr_o), 32'(16'h8000));
        check("log_type_unm",  32'(err_type_o), 32'(2'b01));
`endif

        // Timeout: slave3 hangs, terminated on access cycle TO+1
        wait_cfg[3] = HANG;
        apb_read(16'h2004, 4'b1000, 1'b1, ERR_D, TO + 1);
        check("tout_pulses1", 32'(tout_pulses), 32'(1));
        // Setup for the next transfer arrives in the abort cycle and is held
        PSEL = 1'b1; PENABLE = 1'b0; PADDR = 16'h0014;
        exp_q.push_back({1'b0, 8'hA5});
        @(negedge PCLK);
        check("abort_sel",    32'(SLV_PSEL), 32'(0));
        check("abort_pready", 32'(PREADY), 32'(0));
        check("sticky_set",   32'(tout_sticky_o), 32'(1));
        @(posedge PCLK); #1;
        @(negedge PCLK);
        check("held_sel", 32'(SLV_PSEL), 32'(4'b0010));
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(negedge PCLK);
        check("held_pready", 32'(PREADY), 32'(1));
        if (exp_q.size() > 0) check("held_resp", 32'({PSLVERR, PRDATA}), 32'(exp_q.pop_front()));
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        idle(3);
        @(negedge PCLK);
        check("sticky_hold", 32'(tout_sticky_o), 32'(1));
`ifdef RV_SOC_APB_DECODER_ERRLOG_EN
        check("log_type_first", 32'(err_type_o), 32'(2'b01));
`endif
        @(posedge PCLK); #1;
        tout_clr_i = 1'b1;
        @(posedge PCLK); #1;
        tout_clr_i = 1'b0;
        @(negedge PCLK);
        check("sticky_clr", 32'(tout_sticky_o), 32'(0));
`ifdef RV_SOC_APB_DECODER_ERRLOG_EN
        check("log_valid_clr", 32'(err_valid_o), 32'(0));
        check("log_addr_clr",  32'(err_addr_o), 32'(0));
`endif

        // Slave error after 3 wait states, no timeout
        wait_cfg[0] = 3; SLV_PSLVERR[0] = 1'b1;
        apb_read(16'h0008, 4'b0001, 1'b1, 8'h3C, 4);
        check("no_tout_ws3", 32'(tout_pulses), 32'(1));
`ifdef RV_SOC_APB_DECODER_ERRLOG_EN
        check("log_addr_slv", 32'(err_addr_o), 32'(16'h0008));
        check("log_type_slv", 32'(err_type_o), 32'(2'b11));
`endif
        // Slave ready on the watchdog cycle completes normally
        wait_cfg[0] = TO; SLV_PSLVERR[0] = 1'b0;
        apb_read(16'h0000, 4'b0001, 1'b0, 8'h3C, TO + 1);
        check("no_tout_edge", 32'(tout_pulses), 32'(1));
        wait_cfg[0] = 0;

        // Timeout coinciding with a held clear: set wins
        tout_clr_i = 1'b1;
        apb_read(16'h2000, 4'b1000, 1'b1, ERR_D, TO + 1);
        tout_clr_i = 1'b0;
        @(negedge PCLK);
        check("sticky_set_wins", 32'(tout_sticky_o), 32'(1));
        check("tout_pulses2", 32'(tout_pulses), 32'(2));

        // Reset in the middle of a waiting access
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PADDR = 16'h2008;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        repeat (2) @(posedge PCLK);
        #1;
        PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
        @(negedge PCLK);
        check("mid_rst_pready", 32'(PREADY), 32'(0));
        check("mid_rst_sticky", 32'(tout_sticky_o), 32'(0));
        check("mid_rst_sel",    32'(SLV_PSEL), 32'(0));
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        apb_read(16'h0014, 4'b0010, 1'b0, 8'hA5, 1);
        check("post_rst_tout", 32'(tout_pulses), 32'(2));

        check("exp_q_empty", 32'(exp_q.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
